// File: rtl/lsu_pkg.sv
// Shared types for the data-memory load/store unit.
// Access sizes, FSM states and the alignment check.
package lsu_pkg;

  localparam int DWORD_W = 64;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2,
    SIZE_D = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_e;

  function automatic logic misaligned(
    input size_e      s,
    input logic [2:0] off
  );
    unique case (s)
      SIZE_B:  misaligned = 1'b0;
      SIZE_H:  misaligned = off[0];
      SIZE_W:  misaligned = |off[1:0];
      default: misaligned = |off;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// Request/response handshake plus the data_memory port.
// slave = the LSU, master = CPU side and memory responder.
interface dmem_lsu_if #(
  parameter int ADDR_W = 48
);
  import lsu_pkg::*;

  logic               req_valid;
  logic               req_ready;
  logic               req_we;
  logic [1:0]         req_size;
  logic               req_unsigned;
  logic [63:0]        req_addr;
  logic [DWORD_W-1:0] req_wdata;
  logic               resp_valid;
  logic               resp_ready;
  logic [DWORD_W-1:0] resp_rdata;
  logic               resp_err;
  logic [ADDR_W-1:0]  mem_address;
  logic               mem_Read;
  logic               mem_Write;
  logic [DWORD_W-1:0] mem_write_data;
  logic [DWORD_W-1:0] mem_read_data;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned,
    input  req_addr, req_wdata, resp_ready, mem_read_data,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_address, mem_Read, mem_Write, mem_write_data
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned,
    output req_addr, req_wdata, resp_ready, mem_read_data,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_address, mem_Read, mem_Write, mem_write_data
  );

endinterface

// File: rtl/lsu_lane_align.sv
// Little-endian lane logic: load extract/extend and
// store mask/merge into a sampled doubleword.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  size_e              i_size,
  input  logic               i_uns,
  input  logic [2:0]         i_off,
  input  logic [DWORD_W-1:0] i_rdata,
  input  logic [DWORD_W-1:0] i_wdata,
  output logic [DWORD_W-1:0] o_load,
  output logic [DWORD_W-1:0] o_merge
);

  logic [5:0]         w_sh;
  logic [DWORD_W-1:0] w_rsh;
  logic [DWORD_W-1:0] w_mask;
  logic [DWORD_W-1:0] w_lmask;

  assign w_sh  = {i_off, 3'b000};
  assign w_rsh = i_rdata >> w_sh;

  always_comb begin
    o_load = w_rsh;
    w_mask = '1;
    unique case (i_size)
      SIZE_B: begin
        w_mask = 64'hFF;
        o_load = i_uns ? {56'd0, w_rsh[7:0]}
                       : {{56{w_rsh[7]}}, w_rsh[7:0]};
      end
      SIZE_H: begin
        w_mask = 64'hFFFF;
        o_load = i_uns ? {48'd0, w_rsh[15:0]}
                       : {{48{w_rsh[15]}}, w_rsh[15:0]};
      end
      SIZE_W: begin
        w_mask = 64'hFFFF_FFFF;
        o_load = i_uns ? {32'd0, w_rsh[31:0]}
                       : {{32{w_rsh[31]}}, w_rsh[31:0]};
      end
      SIZE_D: begin
        w_mask = '1;
        o_load = w_rsh;
      end
    endcase
  end

  assign w_lmask = w_mask << w_sh;
  assign o_merge = (i_rdata & ~w_lmask)
                 | ((i_wdata << w_sh) & w_lmask);

endmodule

// File: rtl/dmem_lsu.sv
// Load/store initiator for data_memory: one request at
// a time, RMW for partial stores, alignment/range faults.
module dmem_lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W     = 48,
  parameter int RD_LATENCY = 1
) (
  input logic       clk,
  input logic       rst_n,
  dmem_lsu_if.slave bus
);

  localparam int CW =
    (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  state_e             r_state;
  logic [CW-1:0]      r_cnt;
  logic               r_we;
  logic               r_uns;
  size_e              r_size;
  logic [2:0]         r_off;
  logic [DWORD_W-1:0] r_wdata;
  logic               r_resp_valid;
  logic               r_resp_err;
  logic [DWORD_W-1:0] r_rdata;
  logic               r_rd;
  logic               r_wr;
  logic [ADDR_W-1:0]  r_maddr;
  logic [DWORD_W-1:0] r_mwdata;

  logic               w_accept;
  logic               w_err;
  size_e              w_size;
  logic [DWORD_W-1:0] w_load;
  logic [DWORD_W-1:0] w_merge;

  assign bus.req_ready      = (r_state == IDLE) && rst_n;
  assign bus.resp_valid     = r_resp_valid;
  assign bus.resp_err       = r_resp_err;
  assign bus.resp_rdata     = r_rdata;
  assign bus.mem_address    = r_maddr;
  assign bus.mem_Read       = r_rd;
  assign bus.mem_Write      = r_wr;
  assign bus.mem_write_data = r_mwdata;

  assign w_accept = bus.req_valid && bus.req_ready;
  assign w_size   = size_e'(bus.req_size);
  // high bits beyond the doubleword index make the access out of range
  assign w_err = misaligned(w_size, bus.req_addr[2:0])
              || ((bus.req_addr >> (ADDR_W + 3)) != 64'd0);

  lsu_lane_align u_align (
    .i_size  (r_size),
    .i_uns   (r_uns),
    .i_off   (r_off),
    .i_rdata (bus.mem_read_data),
    .i_wdata (r_wdata),
    .o_load  (w_load),
    .o_merge (w_merge)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_we         <= 1'b0;
      r_uns        <= 1'b0;
      r_size       <= SIZE_B;
      r_off        <= '0;
      r_wdata      <= '0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_rdata      <= '0;
      r_rd         <= 1'b0;
      r_wr         <= 1'b0;
      r_maddr      <= '0;
      r_mwdata     <= '0;
    end else begin
      unique case (r_state)
        IDLE: if (w_accept) begin
          r_we    <= bus.req_we;
          r_uns   <= bus.req_unsigned;
          r_size  <= w_size;
          r_off   <= bus.req_addr[2:0];
          r_wdata <= bus.req_wdata;
          r_maddr <= bus.req_addr[ADDR_W+2:3];
          r_cnt   <= CW'(RD_LATENCY - 1);
          r_rdata <= '0;
          if (w_err) begin
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b1;
            r_state      <= RESP;
          end else if (bus.req_we && w_size == SIZE_D) begin
            r_mwdata <= bus.req_wdata;
            r_wr     <= 1'b1;
            r_state  <= WR;
          end else begin
            r_rd    <= 1'b1;
            r_state <= RD;
          end
        end
        RD: if (r_cnt != '0) begin
          r_cnt <= r_cnt - 1'b1;
        end else begin
          r_rd <= 1'b0;
          if (r_we) begin
            r_mwdata <= w_merge;
            r_wr     <= 1'b1;
            r_state  <= WR;
          end else begin
            r_rdata      <= w_load;
            r_resp_valid <= 1'b1;
            r_state      <= RESP;
          end
        end
        WR: begin
          r_wr         <= 1'b0;
          r_resp_valid <= 1'b1;
          r_state      <= RESP;
        end
        RESP: if (bus.resp_ready) begin
          r_resp_valid <= 1'b0;
          r_resp_err   <= 1'b0;
          r_rdata      <= '0;
          r_state      <= IDLE;
        end
      endcase
    end
  end

endmodule
